delay_timer_arbiter: RTL and testbench
======================================

DELAY_TIMER_ARBITER -- requirements
Module: delay_timer_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing the single delay counter (legal range 2..16).
REQ-002 Parameter COUNT_WIDTH, default 16, SHALL set the width of delay values and of the internal counter.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid  input  NUM_REQ  SHALL carry per-requester delay requests; bit i belongs to requester i.
REQ-006 req_delay  input  NUM_REQ*COUNT_WIDTH  SHALL carry the per-requester delay; slice [i*COUNT_WIDTH +: COUNT_WIDTH] belongs to requester i.
REQ-007 req_ready  output  NUM_REQ  SHALL be the one-hot acceptance indication; a request is accepted when req_valid[i] and req_ready[i] are both high on the same rising edge.
REQ-008 cnt_en  input  1  SHALL gate counting; low freezes the running count.
REQ-009 abort  input  1  SHALL cancel the running delay.
REQ-010 done_pulse  output  NUM_REQ  SHALL give a one-cycle completion pulse to the owning requester.
REQ-011 busy  output  1  SHALL be high while a delay is owned (states COUNT and DONE).
REQ-012 active_id  output  max(1,$clog2(NUM_REQ))  SHALL identify the current owner; it holds its last value when idle.
REQ-013 count_out  output  COUNT_WIDTH  SHALL expose the internal counter value.

Function
REQ-014 FSM SHALL have exactly three states: IDLE, COUNT and DONE.
REQ-015 In IDLE with any req_valid high, req_ready SHALL be combinationally one-hot on the round-robin winner; otherwise req_ready SHALL be all zero.
REQ-016 Outside IDLE, req_ready SHALL be all zero.
REQ-017 Round-robin search SHALL start at (last_grant+1) mod NUM_REQ and wrap to index 0 after NUM_REQ-1.
REQ-018 On acceptance (IDLE, handshake):
- the winner's delay D SHALL be latched;
- active_id SHALL take the winner index;
- last_grant SHALL update to the winner;
- the counter SHALL load 0;
- the next state SHALL be COUNT.
REQ-019 Changes to req_delay after acceptance SHALL be ignored.
REQ-020 In COUNT, the counter SHALL increment by 1 per cycle only while cnt_en=1 and counter<D; otherwise it SHALL hold (no wrap).
REQ-021 In COUNT, when counter==D and abort=0, the next state SHALL be DONE.
REQ-022 In DONE, done_pulse[active_id] SHALL be high for exactly that one cycle; the next state SHALL be IDLE.
REQ-023 Latency: acceptance at edge T SHALL give done_pulse high in cycle T+D+2 when cnt_en is held at 1.
- D=0 SHALL give done_pulse at T+2.
- Each cycle with cnt_en=0 (before the counter reaches D) SHALL add one cycle.
REQ-024 The next acceptance SHALL be possible at the earliest in the cycle after DONE, giving back-to-back spacing of D+3 cycles.
REQ-025 abort=1 in COUNT SHALL return the FSM to IDLE on the next edge and SHALL suppress done_pulse; abort takes priority over reaching D in the same cycle.
REQ-026 abort SHALL be ignored in IDLE and DONE.
REQ-027 D = 2^COUNT_WIDTH-1 SHALL complete normally, with no counter overflow.
REQ-028 done_pulse SHALL be zero in every state except DONE.
REQ-029 A requester whose req_valid stays high after completion SHALL NOT be granted again while another requester is valid.

Reset
REQ-030 On rst_n low, asynchronously and independently of clk:
- state SHALL go to IDLE;
- counter, latched D, active_id and done_pulse SHALL go to 0;
- last_grant SHALL go to NUM_REQ-1, so requester 0 wins first.
REQ-031 Reset asserted during COUNT or DONE SHALL discard the delay with no done_pulse.
REQ-032 After rst_n deasserts, the first acceptance SHALL be possible on the first rising edge.

Verification
REQ-033 Single request: req_valid=4'b0010, delay 5, cnt_en=1, accepted at edge T -> done_pulse=4'b0010 only in cycle T+7, busy high T+1..T+7, active_id=1.
REQ-034 Round-robin: all four valid continuously, delay 0 -> grant order 0,1,2,3,0 with one done_pulse every 3 cycles.
REQ-035 Pause: delay 3, cnt_en low for 2 cycles mid-count -> done_pulse delayed by exactly 2 cycles; count_out holds during the pause.
REQ-036 Abort: delay 10, abort pulsed when count_out=4 -> IDLE on the next edge, no done_pulse, next request accepted the cycle after.
REQ-037 Reset mid-operation: rst_n low while count_out=3 -> all outputs 0 immediately; after release, requester 0 wins when 0 and 2 are both valid.
REQ-038 Max delay: COUNT_WIDTH=4, delay 15 -> done at T+17, count_out saturates at 15 with no wrap.

Source files
------------

// File: rtl/delay_timer_arbiter.sv
// delay_timer_arbiter: round-robin arbiter in front of one shared delay counter.
// A requester that wins arbitration owns the counter until its delay expires
// (one-cycle done_pulse) or until abort cancels it.
module delay_timer_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int COUNT_WIDTH = 16,
    localparam int AW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*COUNT_WIDTH-1:0] req_delay,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic                           cnt_en,
    input  logic                           abort,
    output logic [NUM_REQ-1:0]             done_pulse,
    output logic                           busy,
    output logic [AW-1:0]                  active_id,
    output logic [COUNT_WIDTH-1:0]         count_out
);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    state_t               state, state_nxt;
    logic [COUNT_WIDTH-1:0] counter;
    logic [COUNT_WIDTH-1:0] dly;
    logic [AW-1:0]          last_grant;

    logic                   grant_found;
    logic [AW-1:0]          grant_idx;
    logic [NUM_REQ-1:0]     grant_onehot;
    logic [NUM_REQ-1:0]     owner_onehot;
    logic [COUNT_WIDTH-1:0] sel_delay;
    logic                   accept;

    assign count_out = counter;
    assign accept    = (state == IDLE) && grant_found;

    // Round-robin pick: lowest valid index above last_grant, else lowest valid
    // overall (the wrap case). Scanning downward leaves the lowest match last.
    always_comb begin
        logic          hi_found, lo_found;
        logic [AW-1:0] hi_idx, lo_idx;
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_found = 1'b1;
                lo_idx   = AW'(i);
                if (AW'(i) > last_grant) begin
                    hi_found = 1'b1;
                    hi_idx   = AW'(i);
                end
            end
        end
        grant_found = lo_found;
        grant_idx   = hi_found ? hi_idx : lo_idx;
    end

    // Decode winner/owner to one-hot and mux out the winner's delay.
    always_comb begin
        grant_onehot = '0;
        owner_onehot = '0;
        sel_delay    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_onehot[i] = grant_found && (AW'(i) == grant_idx);
            owner_onehot[i] = (AW'(i) == active_id);
            if (AW'(i) == grant_idx)
                sel_delay = req_delay[i*COUNT_WIDTH +: COUNT_WIDTH];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and outputs; abort beats reaching the target in COUNT.
    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        done_pulse = '0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                req_ready = grant_onehot;
                if (accept) state_nxt = COUNT;
            end
            COUNT: begin
                busy = 1'b1;
                if (abort)               state_nxt = IDLE;
                else if (counter == dly) state_nxt = DONE;
            end
            DONE: begin
                busy       = 1'b1;
                done_pulse = owner_onehot;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ownership capture on acceptance; counter saturates at the latched delay.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter    <= '0;
            dly        <= '0;
            active_id  <= '0;
            last_grant <= AW'(NUM_REQ - 1);
        end else if (accept) begin
            counter    <= '0;
            dly        <= sel_delay;
            active_id  <= grant_idx;
            last_grant <= grant_idx;
        end else if (state == COUNT && cnt_en && counter < dly) begin
            counter <= counter + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Bench for delay_timer_arbiter: expected done pulses (cycle, mask) are queued
// when a request is accepted and checked by a monitor when pulses appear.
module tb_delay_timer_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_delay = '0;
    logic [N-1:0]   req_ready;
    logic           cnt_en = 1'b1;
    logic           abort = 1'b0;
    logic [N-1:0]   done_pulse;
    logic           busy;
    logic [1:0]     active_id;
    logic [W-1:0]   count_out;

    typedef struct {
        int           cyc;
        logic [N-1:0] mask;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;

    delay_timer_arbiter #(.NUM_REQ(N), .COUNT_WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_delay  (req_delay),
        .req_ready  (req_ready),
        .cnt_en     (cnt_en),
        .abort      (abort),
        .done_pulse (done_pulse),
        .busy       (busy),
        .active_id  (active_id),
        .count_out  (count_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every pulse must match the head of the queue.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_missed: no pulse observed, required mask %b at cycle %0d", sb[0].mask, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (done_pulse !== '0) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL done_unexpected: got %b at cycle %0d, required none", done_pulse, cyc);
            end else begin
                e_mon = sb.pop_front();
                if (e_mon.cyc != cyc || e_mon.mask !== done_pulse) begin
                    n_fail++;
                    $display("FAIL done_pulse: got %b at cycle %0d, required %b at cycle %0d",
                             done_pulse, cyc, e_mon.mask, e_mon.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_delay(input int i, input int d);
        req_delay[i*W +: W] = W'(d);
    endtask

    task automatic test_reset();
        #1;
        n_chk++;
        if (busy !== 1'b0 || count_out !== '0 || active_id !== '0 || done_pulse !== '0 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b cnt=%0d id=%0d done=%b ready=%b, required all 0",
                     busy, count_out, active_id, done_pulse, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin();
        int order [5] = '{0, 1, 2, 3, 0};
        int t;
        for (int i = 0; i < N; i++) set_delay(i, 0);
        req_valid = 4'b1111;
        #1;
        for (int g = 0; g < 5; g++) begin
            n_chk++;
            if (req_ready !== N'(1 << order[g])) begin
                n_fail++;
                $display("FAIL rr_ready[%0d]: got %b, required %b", g, req_ready, N'(1 << order[g]));
            end
            tick();
            t = cyc;
            sb.push_back('{t + 1, N'(1 << order[g])});
            n_chk++;
            if (active_id !== 2'(order[g]) || req_ready !== '0) begin
                n_fail++;
                $display("FAIL rr_count[%0d]: id=%0d ready=%b, required id=%0d ready=0000",
                         g, active_id, req_ready, order[g]);
            end
            tick();
            n_chk++;
            if (req_ready !== '0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL rr_done[%0d]: ready=%b busy=%b, required 0000/1", g, req_ready, busy);
            end
            tick();
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_single();
        int t;
        set_delay(1, 5);
        req_valid = 4'b0010;
        #1;
        n_chk++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL single_ready: got %b, required 0010", req_ready);
        end
        tick();
        t = cyc;
        sb.push_back('{t + 6, 4'b0010});
        req_valid = '0;
        set_delay(1, 1);
        n_chk++;
        if (active_id !== 2'd1) begin
            n_fail++;
            $display("FAIL single_id: got %0d, required 1", active_id);
        end
        for (int k = 0; k <= 7; k++) begin
            n_chk++;
            if (busy !== (k <= 6)) begin
                n_fail++;
                $display("FAIL single_busy[%0d]: got %b, required %b", k, busy, k <= 6);
            end
            if (k <= 6) begin
                n_chk++;
                if (count_out !== W'((k < 5) ? k : 5)) begin
                    n_fail++;
                    $display("FAIL single_count[%0d]: got %0d, required %0d", k, count_out, (k < 5) ? k : 5);
                end
            end
            tick();
        end
    endtask

    task automatic test_pause();
        int t;
        set_delay(2, 3);
        req_valid = 4'b0100;
        tick();
        t = cyc;
        sb.push_back('{t + 6, 4'b0100});
        req_valid = '0;
        tick();
        cnt_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_chk++;
            if (count_out !== W'(1)) begin
                n_fail++;
                $display("FAIL pause_hold[%0d]: got %0d, required 1", k, count_out);
            end
        end
        cnt_en = 1'b1;
        repeat (5) tick();
    endtask

    task automatic test_abort();
        int t;
        set_delay(3, 10);
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
        repeat (4) tick();
        n_chk++;
        if (count_out !== W'(4)) begin
            n_fail++;
            $display("FAIL abort_count: got %0d, required 4", count_out);
        end
        abort = 1'b1;
        tick();
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: busy=%b, required 0", busy);
        end
        // abort held high in IDLE must not block acceptance
        set_delay(0, 0);
        req_valid = 4'b0001;
        #1;
        n_chk++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL abort_next_ready: got %b, required 0001", req_ready);
        end
        tick();
        t = cyc;
        sb.push_back('{t + 1, 4'b0001});
        abort = 1'b0;
        req_valid = '0;
        n_chk++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_next_busy: got %b, required 1", busy);
        end
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        // abort in the cycle the counter reaches D wins: no pulse
        set_delay(1, 2);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        repeat (2) tick();
        n_chk++;
        if (count_out !== W'(2) || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_at_d: cnt=%0d busy=%b, required 2/1", count_out, busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_at_d_idle: busy=%b, required 0", busy);
        end
        repeat (3) tick();
    endtask

    task automatic test_reset_mid();
        int t;
        set_delay(2, 10);
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        repeat (3) tick();
        n_chk++;
        if (count_out !== W'(3)) begin
            n_fail++;
            $display("FAIL rstmid_count: got %0d, required 3", count_out);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (busy !== 1'b0 || count_out !== '0 || active_id !== '0 || done_pulse !== '0 || req_ready !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: busy=%b cnt=%0d id=%0d done=%b ready=%b, required all 0",
                     busy, count_out, active_id, done_pulse, req_ready);
        end
        set_delay(0, 0);
        req_valid = 4'b0101;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_chk++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL rstmid_ready: got %b, required 0001", req_ready);
        end
        tick();
        t = cyc;
        sb.push_back('{t + 1, 4'b0001});
        req_valid = '0;
        n_chk++;
        if (active_id !== 2'd0) begin
            n_fail++;
            $display("FAIL rstmid_id: got %0d, required 0", active_id);
        end
        repeat (3) tick();
    endtask

    task automatic test_max_delay();
        int t;
        set_delay(1, 15);
        req_valid = 4'b0010;
        tick();
        t = cyc;
        sb.push_back('{t + 16, 4'b0010});
        req_valid = '0;
        for (int k = 0; k <= 16; k++) begin
            if (k == 0 || k >= 14) begin
                n_chk++;
                if (count_out !== W'((k < 15) ? k : 15)) begin
                    n_fail++;
                    $display("FAIL max_count[%0d]: got %0d, required %0d", k, count_out, (k < 15) ? k : 15);
                end
            end
            tick();
        end
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single();
        test_pause();
        test_abort();
        test_reset_mid();
        test_max_delay();
        repeat (5) tick();
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d pulses outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
